// File: rtl/fp16_add_arbiter_if.sv
// fp16_add_arbiter_if: requester and response bundle for fp16_add_arbiter.
// slave = arbiter side, master = requesters/consumer side.
interface fp16_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0][15:0] req_a_i;
  logic [NUM_REQ-1:0][15:0] req_b_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [15:0]              rsp_data_o;
  logic [ID_W-1:0]          rsp_id_o;
  logic [1:0]               busy_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o,
    output rsp_data_o, rsp_id_o, busy_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_data_o, rsp_id_o, busy_o
  );
endinterface

// File: rtl/fp16_add_arbiter.sv
// fp16_add_arbiter: round-robin share of one FP16 adder, 2-stage pipe.
// Ports: CLK_i, RST_i (async low), bus (fp16_add_arbiter_if.slave).
// Option FP16_ADD_ARB_PRIO_EN: requester 0 gets absolute priority.
module new_fp_16_add (
  input  logic [31:0] operands_i,
  output logic [15:0] result_o
);
  logic [15:0] a, b, x, y;
  logic [4:0]  ex, ey, d;
  logic [10:0] mx, my;
  logic [37:0] al;
  logic [13:0] xe, ye, n;
  logic [14:0] s;
  logic [5:0]  e, sh, lz6;
  logic [3:0]  lz;
  logic [11:0] mr;
  logic        sub, rnd, nan_a, nan_b;

  always_comb begin
    a = operands_i[15:0];
    b = operands_i[31:16];
    // x always carries the larger magnitude
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx = {x[14:10] != 5'd0, x[9:0]};
    my = {y[14:10] != 5'd0, y[9:0]};
    d  = ex - ey;
    al = {my, 27'd0} >> ((d > 5'd26) ? 5'd26 : d);
    // 3 extra bits: guard, round, sticky
    xe = {mx, 3'b000};
    ye = {al[37:25], al[24] | (|al[23:0])};
    sub = x[15] ^ y[15];
    if (sub) s = {1'b0, xe} - {1'b0, ye};
    else     s = {1'b0, xe} + {1'b0, ye};
    e  = {1'b0, ex};
    lz = 4'd0;
    for (int i = 0; i < 14; i++)
      if (s[i]) lz = 4'(13 - i);
    lz6 = {2'b00, lz};
    sh  = 6'd0;
    if (s[14]) begin
      n = {s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end else begin
      // never normalise below the minimum exponent
      sh = (lz6 > e - 6'd1) ? e - 6'd1 : lz6;
      n  = s[13:0] << sh;
      e  = e - sh;
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[13:3]} + {11'd0, rnd};
    if (mr[11]) begin
      e  = e + 6'd1;
      mr = {1'b0, mr[11:1]};
    end else if (!mr[10]) begin
      e = 6'd0;
    end
    nan_a = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    nan_b = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    if (nan_a || nan_b)
      result_o = 16'h7e00;
    else if (x[14:10] == 5'h1f)
      result_o = (sub && y[14:10] == 5'h1f)
               ? 16'h7e00 : {x[15], 15'h7c00};
    else if (s == 15'd0)
      result_o = {x[15] & ~sub, 15'd0};
    else if (e >= 6'd31)
      result_o = {x[15], 15'h7c00};
    else
      result_o = {x[15], e[4:0], mr[9:0]};
  end
endmodule

module fp16_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic               CLK_i,
  input logic               RST_i,
  fp16_add_arbiter_if.slave bus
);
`ifdef FP16_ADD_ARB_PRIO_EN
  localparam logic [ID_W-1:0] RR_RST = ID_W'(1);
`else
  localparam logic [ID_W-1:0] RR_RST = '0;
`endif
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  logic            s1_vld, s2_vld;
  logic [15:0]     s1_a, s1_b, s2_sum, sum;
  logic [ID_W-1:0] s1_id, s2_id, rr_ptr, win, nxt;
  logic            hit, grant, s1_adv, s2_adv;

  assign s2_adv = !s2_vld || bus.rsp_ready_i;
  assign s1_adv = !s1_vld || s2_adv;
  assign grant  = hit && s1_adv;

  always_comb begin
    int j;
    win = '0;
    hit = 1'b0;
    j   = 0;
`ifdef FP16_ADD_ARB_PRIO_EN
    if (bus.req_valid_i[0]) hit = 1'b1;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - (NUM_REQ - 1);
      if (!hit && bus.req_valid_i[j]) begin
        hit = 1'b1;
        win = ID_W'(j);
      end
    end
    nxt = (win == LAST) ? ID_W'(1) : win + 1'b1;
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!hit && bus.req_valid_i[j]) begin
        hit = 1'b1;
        win = ID_W'(j);
      end
    end
    nxt = (win == LAST) ? '0 : win + 1'b1;
`endif
  end

  assign bus.req_ready_o =
    grant ? (NUM_REQ'(1) << win) : '0;

  new_fp_16_add u_add (
    .operands_i({s1_b, s1_a}),
    .result_o  (sum)
  );

  always_ff @(posedge CLK_i or negedge RST_i) begin
    if (!RST_i) begin
      rr_ptr <= RR_RST;
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
      s2_vld <= 1'b0;
      s2_sum <= '0;
      s2_id  <= '0;
    end else begin
`ifdef FP16_ADD_ARB_PRIO_EN
      if (grant && win != '0) rr_ptr <= nxt;
`else
      if (grant) rr_ptr <= nxt;
`endif
      if (s1_adv) begin
        s1_vld <= grant;
        if (grant) begin
          s1_a  <= bus.req_a_i[win];
          s1_b  <= bus.req_b_i[win];
          s1_id <= win;
        end
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        s2_sum <= sum;
        s2_id  <= s1_id;
      end
    end
  end

  assign bus.rsp_valid_o = s2_vld;
  assign bus.rsp_data_o  = s2_sum;
  assign bus.rsp_id_o    = s2_id;
  assign bus.busy_o      = {1'b0, s1_vld} + {1'b0, s2_vld};
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// tb_fp16_add_arbiter: directed bench with a queue-based reference model.
// Model: in-flight queue with ages, round-robin pointer, sum table.
module tb_fp16_add_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [3:0] oneshot = '0;

  always #5 clk = ~clk;

  fp16_add_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  fp16_add_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .CLK_i(clk),
    .RST_i(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Hand-computed FP16 sums for every operand pair the bench uses.
  function automatic logic [15:0] exp_sum(input logic [15:0] a,
                                          input logic [15:0] b);
    case ({a, b})
      32'h3c00_3c00: return 16'h4000;
      32'h4000_3c00: return 16'h4200;
      32'h4200_bc00: return 16'h4000;
      32'h3c00_3800: return 16'h3e00;
      32'h0001_0001: return 16'h0002;
      32'h7c00_3c00: return 16'h7c00;
      32'h3c00_bc00: return 16'h0000;
      32'h7bff_7bff: return 16'h7c00;
      32'h7e00_3c00: return 16'h7e00;
      32'h7c00_fc00: return 16'h7e00;
      default:       return 16'hffff;
    endcase
  endfunction

`ifdef FP16_ADD_ARB_PRIO_EN
  localparam int RR0 = 1;
`else
  localparam int RR0 = 0;
`endif

  function automatic int pick(input logic [3:0] v, input int ptr);
`ifdef FP16_ADD_ARB_PRIO_EN
    if (v[0]) return 0;
    for (int k = 0; k < 3; k++)
      if (v[1 + (ptr - 1 + k) % 3]) return 1 + (ptr - 1 + k) % 3;
`else
    for (int k = 0; k < 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [15:0] sum;
    int          age;
  } item_t;

  item_t       q[$];
  int          rr = RR0;
  int          log_id[$];
  logic [15:0] log_data[$];

  always @(negedge clk) begin
    int   w;
    logic can, ev;
    logic [3:0] er;
    if (!rst_n) begin
      q.delete();
      rr = RR0;
      check("rst_valid", 32'(bus.rsp_valid_o), 0);
      check("rst_busy", 32'(bus.busy_o), 0);
    end else begin
      w   = pick(bus.req_valid_i, rr);
      can = (q.size() < 2) || bus.rsp_ready_i;
      er  = (w >= 0 && can) ? 4'(1 << w) : 4'd0;
      ev  = (q.size() > 0) && (q[0].age >= 2);
      check("req_ready", 32'(bus.req_ready_o), 32'(er));
      check("rsp_valid", 32'(bus.rsp_valid_o), 32'(ev));
      check("busy", 32'(bus.busy_o), q.size());
      if (ev) begin
        check("rsp_data", 32'(bus.rsp_data_o), 32'(q[0].sum));
        check("rsp_id", 32'(bus.rsp_id_o), q[0].id);
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        log_id.push_back(int'(bus.rsp_id_o));
        log_data.push_back(bus.rsp_data_o);
      end
      if (ev && bus.rsp_ready_i) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (w >= 0 && can) begin
        q.push_back('{w, exp_sum(bus.req_a_i[w],
                                 bus.req_b_i[w]), 1});
`ifdef FP16_ADD_ARB_PRIO_EN
        if (w != 0) rr = 1 + w % 3;
`else
        rr = (w + 1) % 4;
`endif
      end
    end
  end

  task automatic step();
    logic [3:0] got;
    @(negedge clk);
    got = bus.req_ready_o & bus.req_valid_i;
    @(posedge clk);
    #1;
    bus.req_valid_i = bus.req_valid_i & ~(got & oneshot);
  endtask

  task automatic set_op(input int r, input logic [15:0] a,
                        input logic [15:0] b);
    bus.req_a_i[r] = a;
    bus.req_b_i[r] = b;
  endtask

  task automatic drain_log();
    log_id.delete();
    log_data.delete();
  endtask

  task automatic check_ids(input string name, input int exp[$]);
    check({name, "_count"}, log_id.size(), exp.size());
    foreach (exp[i])
      if (i < log_id.size())
        check(name, log_id[i], exp[i]);
  endtask

  logic [15:0] va[10] = '{16'h3c00, 16'h4000, 16'h4200, 16'h3c00,
                          16'h0001, 16'h7c00, 16'h3c00, 16'h7bff,
                          16'h7e00, 16'h7c00};
  logic [15:0] vb[10] = '{16'h3c00, 16'h3c00, 16'hbc00, 16'h3800,
                          16'h0001, 16'h3c00, 16'hbc00, 16'h7bff,
                          16'h3c00, 16'hfc00};
  logic [15:0] vs[10] = '{16'h4000, 16'h4200, 16'h4000, 16'h3e00,
                          16'h0002, 16'h7c00, 16'h0000, 16'h7c00,
                          16'h7e00, 16'h7e00};

  initial begin
    int n;
    bus.req_valid_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(bus.rsp_data_o), 0);
    check("reset_id", 32'(bus.rsp_id_o), 0);
    rst_n = 1'b1;

`ifndef FP16_ADD_ARB_PRIO_EN
    // fairness: all four valid continuously
    for (int r = 0; r < 4; r++) set_op(r, 16'h3c00, 16'h3c00);
    drain_log();
    oneshot = '0;
    bus.req_valid_i = 4'hf;
    repeat (8) step();
    bus.req_valid_i = '0;
    repeat (3) step();
    check_ids("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});
    foreach (log_data[i]) check("rr_data", 32'(log_data[i]), 32'h4000);
`endif

    // single request from requester 2
    oneshot = 4'hf;
    set_op(2, 16'h4000, 16'h3c00);
    bus.req_valid_i = 4'b0100;
    step();
    check("single_busy1", 32'(bus.busy_o), 1);
    step();
    check("single_busy2", 32'(bus.busy_o), 1);
    check("single_valid", 32'(bus.rsp_valid_o), 1);
    check("single_data", 32'(bus.rsp_data_o), 32'h4200);
    check("single_id", 32'(bus.rsp_id_o), 2);
    step();
    check("single_busy3", 32'(bus.busy_o), 0);
    check("single_done", 32'(bus.rsp_valid_o), 0);

`ifndef FP16_ADD_ARB_PRIO_EN
    // wrap-around from rr_ptr=3 with requesters 3 and 0
    set_op(3, 16'h0001, 16'h0001);
    set_op(0, 16'h4200, 16'hbc00);
    drain_log();
    oneshot = '0;
    bus.req_valid_i = 4'b1001;
    repeat (4) step();
    bus.req_valid_i = '0;
    repeat (3) step();
    check_ids("wrap_order", '{3, 0, 3, 0});
    if (log_data.size() == 4) begin
      check("wrap_d0", 32'(log_data[0]), 32'h0002);
      check("wrap_d1", 32'(log_data[1]), 32'h4000);
    end
`endif

    // directed operand vectors, one at a time
    oneshot = 4'hf;
    foreach (va[v]) begin
      drain_log();
      set_op(v % 4, va[v], vb[v]);
      bus.req_valid_i[v % 4] = 1'b1;
      n = 0;
      while (log_id.size() == 0 && n < 20) begin
        step();
        n++;
      end
      check("vec_timeout", 32'(n < 20), 1);
      if (log_id.size() > 0) begin
        check($sformatf("vec%0d_data", v), 32'(log_data[0]),
              32'(vs[v]));
        check($sformatf("vec%0d_id", v), log_id[0], v % 4);
      end
      bus.req_valid_i = '0;
      repeat (2) step();
    end

    // backpressure with two in flight
    set_op(1, 16'h3c00, 16'h3800);
    set_op(2, 16'h4000, 16'h3c00);
    set_op(3, 16'h0001, 16'h0001);
    drain_log();
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    step();
    bus.req_valid_i = 4'b0100;
    step();
    bus.req_valid_i = 4'b1000;
    repeat (5) begin
      step();
      check("bp_busy", 32'(bus.busy_o), 2);
      check("bp_ready", 32'(bus.req_ready_o), 0);
      check("bp_id", 32'(bus.rsp_id_o), 1);
      check("bp_data", 32'(bus.rsp_data_o), 32'h3e00);
    end
    bus.rsp_ready_i = 1'b1;
    repeat (5) step();
    check_ids("bp_order", '{1, 2, 3});

    // async reset with two in flight
    set_op(0, 16'h3c00, 16'h3c00);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0001;
    step();
    bus.req_valid_i = 4'b0010;
    step();
    check("mid_busy", 32'(bus.busy_o), 2);
    bus.req_valid_i = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.rsp_valid_o), 0);
    check("mid_rst_busy", 32'(bus.busy_o), 0);
    check("mid_rst_data", 32'(bus.rsp_data_o), 0);
    check("mid_rst_id", 32'(bus.rsp_id_o), 0);
    repeat (2) step();
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    repeat (4) begin
      step();
      check("post_rst_valid", 32'(bus.rsp_valid_o), 0);
    end

`ifdef FP16_ADD_ARB_PRIO_EN
    // requester 0 dominates until it drops
    set_op(0, 16'h3c00, 16'h3c00);
    set_op(1, 16'h3c00, 16'h3800);
    drain_log();
    oneshot = '0;
    bus.req_valid_i = 4'b0011;
    repeat (5) step();
    bus.req_valid_i = 4'b0010;
    step();
    bus.req_valid_i = '0;
    repeat (3) step();
    check_ids("prio_order", '{0, 0, 0, 0, 0, 1});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp16_add_arbiter.md
# fp16_add_arbiter

Round-robin arbiter and two-stage pipeline sequencer that shares one combinational `new_fp_16_add` instance among `NUM_REQ` requesters. Each requester presents an FP16 operand pair with a valid/ready handshake. The block grants at most one request per cycle, registers the operands in front of the adder, and registers the sum behind it. Results come back on a single tagged response port with backpressure.

## Interface
- `NUM_REQ`, default 4: number of requesters; range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag.
- `CLK_i` in, 1: single clock; all state updates on the rising edge.
- `RST_i` in, 1: asynchronous, active-low reset.
- `req_valid_i` in, `NUM_REQ`: per-requester request valid.
- `req_ready_o` out, `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a_i` in, `NUM_REQ`x16: operand A per requester (FP16).
- `req_b_i` in, `NUM_REQ`x16: operand B per requester (FP16).
- `rsp_valid_o` out, 1: result valid.
- `rsp_ready_i` in, 1: consumer accepts result.
- `rsp_data_o` out, 16: A+B result from the adder.
- `rsp_id_o` out, `ID_W`: index of the originating requester.
- `busy_o` out, 2: number of operations in flight (0..2).

## Operation
- Internal stages:
  - S1 registers `s1_vld`, `s1_a`, `s1_b`, `s1_id`.
  - The adder is driven as `operands_i = {s1_b, s1_a}`.
  - S2 registers `s2_vld`, `s2_sum`, `s2_id`. These drive `rsp_*` directly.
- Advance rules, evaluated each cycle:
  - `s2_adv = !s2_vld || rsp_ready_i`.
  - `s1_adv = !s1_vld || s2_adv`.
  - Grant is allowed only when `s1_adv`.
- Arbitration:
  - Round-robin pointer `rr_ptr`.
  - The winner is the first `i` with `req_valid_i[i]`, searching from `rr_ptr` upward modulo `NUM_REQ`.
  - `req_ready_o[winner]=1` combinationally, only when `s1_adv`.
  - The handshake completes when `req_valid_i[i] && req_ready_o[i]`.
  - On a completed handshake, `rr_ptr <= winner+1` modulo `NUM_REQ` (wraps `NUM_REQ-1` -> 0).
  - With no grant, `rr_ptr` holds.
- S1 load:
  - On grant, S1 captures A, B and id, and `s1_vld<=1`.
  - If `s1_adv` with no grant, `s1_vld<=0`.
- S2 load:
  - On `s2_adv`, S2 captures the adder result and `s1_id`, and `s2_vld<=s1_vld`.
- `busy_o = s1_vld + s2_vld`.
- Requesters must hold valid and operands stable until ready. The block places no requirement on requesters that deassert valid without ready.
- `rsp_data_o` and `rsp_id_o` must be stable while `rsp_valid_o && !rsp_ready_i`.
- A requester with valid asserted is granted within `NUM_REQ` grant opportunities (no starvation).

## Timing
- Reset (async assert, sync-safe deassert via flops):
  - `s1_vld`, `s2_vld` = 0; `rr_ptr` = 0.
  - `rsp_valid_o` = 0, `rsp_data_o` = 0, `rsp_id_o` = 0, `busy_o` = 0.
  - `req_ready_o` is combinational. It may be nonzero during reset, but no handshake is recorded while `RST_i`=0.
- Latency: handshake in cycle N gives `rsp_valid_o`=1 in cycle N+2.
- Throughput: one result per cycle with `rsp_ready_i` held high.
- Full pipeline (`s1_vld && s2_vld && !rsp_ready_i`): `req_ready_o`=0 on all bits.
- Response accepted in the same cycle as a new grant: S2 takes S1, S1 takes the new request. No bubble, no loss.
- Reset mid-operation: in-flight results are discarded. No response is emitted after reset release without a new request.

## Configuration
- `FP16_ADD_ARB_PRIO_EN`:
  - Defined: requester 0 has fixed absolute priority. It is granted whenever `req_valid_i[0]` and `s1_adv`, and its grants do not update `rr_ptr`. Round-robin applies among requesters 1..`NUM_REQ-1`, with `rr_ptr` ranging 1..`NUM_REQ-1` (reset value 1).
  - Undefined: pure round-robin over all requesters as in Operation.

## Test plan
- Single request: requester 2 sends A=0x4000 (2.0), B=0x3C00 (1.0) -> after 2 cycles `rsp_valid_o`=1, `rsp_data_o`=0x4200, `rsp_id_o`=2, `busy_o` 1 then 1 then 0.
- Round-robin fairness: all 4 requesters valid continuously with 0x3C00+0x3C00, `rsp_ready_i`=1 -> ids 0,1,2,3,0,1… and every result 0x4000, one per cycle.
- Backpressure: two requests granted, then `rsp_ready_i`=0 for 5 cycles -> `busy_o`=2, all `req_ready_o`=0, `rsp_data_o`/`rsp_id_o` stable. Release -> both results delivered in order, no drop or duplicate.
- Wrap-around: only requesters 3 and 0 valid, starting from `rr_ptr`=3 -> grant order 3,0,3,0.
- Async reset mid-flight: assert `RST_i`=0 with `busy_o`=2 -> outputs go to reset values immediately. After release with no requests, `rsp_valid_o` stays 0.
- With `FP16_ADD_ARB_PRIO_EN`: requesters 0 and 1 continuously valid -> every grant goes to 0 until it drops. Then requester 1 is granted next cycle.
